lcd_init_sequencer: RTL and testbench
=====================================

Name: lcd_init_sequencer

Overview:
- Generic, table-driven LCD bring-up sequencer; successor to the fixed HX8352 init FSM.
- Fetches opcode entries from an external synchronous ROM starting at a caller-selected base address, so one table can hold init, sleep and wake sequences.
- Issues each entry as a command write, a data write or a delay, using the existing bus-writer (bus_step/bus_done) and delay-timer (delay_step/delay_done) handshakes.
- Restartable after completion; owns LCD chip-select for the duration of a sequence.

Parameters:
- DATA_W, 16, bus word width and delay payload width.
- ADDR_W, 8, ROM address width; table depth is 2**ADDR_W.
- TIMEOUT_CYC, 65535, handshake watchdog limit in clk cycles (used only with LCD_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to run a sequence; ignored while busy.
- seq_base  in  ADDR_W  first ROM address of the sequence; sampled on an accepted start.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  DATA_W+2  ROM word, valid 1 cycle after rom_addr; [DATA_W+1:DATA_W]=opcode, [DATA_W-1:0]=payload.
- bus_step  out  1  1-cycle pulse requesting one bus write.
- bus_dc  out  1  0=command, 1=data; stable from bus_step until bus_done.
- bus_data  out  DATA_W  word to write; stable from bus_step until bus_done.
- bus_done  in  1  bus write complete (pulse).
- delay_step  out  1  1-cycle pulse starting the delay timer.
- delay_value  out  DATA_W  delay count; stable until delay_done.
- delay_done  in  1  delay complete (pulse).
- lcd_cs_n  out  1  LCD chip-select, active low.
- busy  out  1  high from an accepted start until the sequence ends.
- done  out  1  level; set at the end of a sequence, cleared by the next accepted start.
- error  out  1  level; watchdog abort flag, cleared by the next accepted start (stays 0 without LCD_SEQ_TIMEOUT_EN).

Behaviour:
- Opcodes: 0=CMD (bus_dc=0, bus_data=payload), 1=DATA (bus_dc=1), 2=DELAY (delay_value=payload), 3=END.
- Reset values: state IDLE; rom_addr=0, bus_step=0, bus_dc=0, bus_data=0, delay_step=0, delay_value=0, lcd_cs_n=1, busy=0, done=0, error=0.
- IDLE: on start, rom_addr<=seq_base, lcd_cs_n<=0, busy<=1, done<=0, error<=0 -> FETCH.
- FETCH: one-cycle wait for ROM latency -> DECODE.
- DECODE: latch rom_data.
  - CMD or DATA -> BUS_ISSUE.
  - DELAY -> DLY_ISSUE; a payload of 0 skips the timer and goes to NEXT.
  - END -> FINISH.
- BUS_ISSUE: bus_step=1 for one cycle, drive bus_dc/bus_data -> BUS_WAIT.
- BUS_WAIT: wait for bus_done -> NEXT. A bus_done seen in the same cycle as bus_step is not counted.
- DLY_ISSUE / DLY_WAIT: same pattern using delay_step and delay_done.
- NEXT: if rom_addr == 2**ADDR_W-1, go to FINISH (implicit END, no wrap); else rom_addr+1 -> FETCH.
- FINISH: lcd_cs_n<=1, busy<=0, done<=1 -> IDLE.
- Per-entry latency: CMD/DATA = 4 cycles + bus latency; start to lcd_cs_n low = 1 cycle.
- Consecutive CMD entries are allowed (command with no parameter). Consecutive DATA entries give multi-word parameters.
- start while busy: ignored, no queuing. start in the same cycle FINISH executes: ignored; the caller re-asserts start.
- Stray bus_done/delay_done outside their wait states: ignored.
- rst mid-sequence: immediate return to reset values; lcd_cs_n released asynchronously.

Optional Feature:
- Macro LCD_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS_WAIT/DLY_WAIT and increments every cycle spent waiting.
  - On reaching TIMEOUT_CYC: error<=1, lcd_cs_n<=1, busy<=0, done stays 0, state -> IDLE.
  - A done pulse arriving in the limit cycle takes priority, so no error is flagged.
- Not defined: no counter logic; waits are unbounded; error is tied to 0.

Decomposition:
- Package lcd_seq_pkg holds:
  - opcode constants (OP_CMD, OP_DATA, OP_DELAY, OP_END);
  - state encodings;
  - an entry-packing function/macro so ROM init files share the encoding.
- One natural sub-module, lcd_seq_watchdog: the timeout counter, instantiated only under LCD_SEQ_TIMEOUT_EN.

Test Plan:
- ROM @0x00 {CMD 0x0011, DELAY 0x0078, CMD 0x0029, DATA 0xA5A5, END}; start, seq_base=0:
  - bus writes (dc,data) = (0,0x0011), (0,0x0029), (1,0xA5A5);
  - exactly one delay_step with value 0x0078;
  - lcd_cs_n low throughout; done=1, busy=0 afterwards.
- Two sequences at 0x00 and 0x40 (second = {CMD 0x0010, END}): run 0x00, then start with seq_base=0x40 -> only (0,0x0010) written; done drops on start and rises again.
- seq_base=0xFE, ROM 0xFE={DATA 1}, 0xFF={DATA 2}, no END -> two writes, then done; rom_addr never shows 0x00.
- Pulse start while busy, and pulse bus_done outside BUS_WAIT -> no extra writes, sequence unchanged.
- Assert rst during BUS_WAIT -> lcd_cs_n=1 and all outputs at reset values in the same cycle; a later start runs the sequence cleanly.
- With LCD_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, bus_done never returned -> error=1 exactly 16 cycles after entering BUS_WAIT, done=0, lcd_cs_n=1; without the macro, busy stays 1.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the table-driven LCD init sequencer.
// ROM entry layout: {opcode[1:0], payload[DATA_W-1:0]}.
package lcd_seq_pkg;

  // Payload width of the default 16-bit table build.
  localparam int unsigned ENTRY_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } opcode_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_BUS_ISSUE,
    S_BUS_WAIT,
    S_DLY_ISSUE,
    S_DLY_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  // Builds one ROM word so table generators and benches share the encoding.
  function automatic logic [ENTRY_DATA_W+1:0] pack_entry(
    input opcode_t                   op,
    input logic [ENTRY_DATA_W-1:0]   payload
  );
    return {op, payload};
  endfunction

endpackage

// File: rtl/lcd_seq_watchdog.sv
// Handshake watchdog for the LCD init sequencer.
// Counts cycles spent in a wait state; flags expiry on the last allowed cycle.
module lcd_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // Wait-cycle counter: cleared on the issue cycle, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = waiting && (count == LIMIT);

endmodule

// File: rtl/lcd_init_sequencer.sv
// Table-driven LCD bring-up sequencer.
// Fetches {opcode,payload} entries from a synchronous ROM starting at seq_base
// and issues them as command/data bus writes or timer delays until END.
// Optional macro LCD_SEQ_TIMEOUT_EN adds a handshake watchdog (TIMEOUT_CYC).
module lcd_init_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] seq_base,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W+1:0] rom_data,
  output logic              bus_step,
  output logic              bus_dc,
  output logic [DATA_W-1:0] bus_data,
  input  logic              bus_done,
  output logic              delay_step,
  output logic [DATA_W-1:0] delay_value,
  input  logic              delay_done,
  output logic              lcd_cs_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t              state, next_state;
  opcode_t             op;
  logic [DATA_W-1:0]   payload;
  logic                accept;
  logic                wait_hit;
  logic                timeout;
  logic                abort;
  logic                last_addr;

  assign op        = opcode_t'(rom_data[DATA_W+1:DATA_W]);
  assign payload   = rom_data[DATA_W-1:0];
  assign accept    = (state == S_IDLE) && start;
  assign last_addr = (rom_addr == '1);
  assign wait_hit  = ((state == S_BUS_WAIT) && bus_done) ||
                     ((state == S_DLY_WAIT) && delay_done);
  // A completion arriving in the limit cycle wins over the watchdog.
  assign abort     = timeout && !wait_hit;

`ifdef LCD_SEQ_TIMEOUT_EN
  lcd_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   ((state == S_BUS_ISSUE) || (state == S_DLY_ISSUE)),
    .waiting ((state == S_BUS_WAIT) || (state == S_DLY_WAIT)),
    .expired (timeout)
  );

  // Abort flag: set by watchdog expiry, cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error <= 1'b0;
    end else if (accept) begin
      error <= 1'b0;
    end else if (abort) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (start) next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_CMD,
          OP_DATA:   next_state = S_BUS_ISSUE;
          OP_DELAY:  next_state = (payload == '0) ? S_NEXT : S_DLY_ISSUE;
          OP_END:    next_state = S_FINISH;
        endcase
      end
      S_BUS_ISSUE: next_state = S_BUS_WAIT;
      S_BUS_WAIT: begin
        if (bus_done)   next_state = S_NEXT;
        else if (abort) next_state = S_IDLE;
      end
      S_DLY_ISSUE: next_state = S_DLY_WAIT;
      S_DLY_WAIT: begin
        if (delay_done) next_state = S_NEXT;
        else if (abort) next_state = S_IDLE;
      end
      S_NEXT:      next_state = last_addr ? S_FINISH : S_FETCH;
      S_FINISH:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Handshake strobes decoded from state.
  always_comb begin
    bus_step   = (state == S_BUS_ISSUE);
    delay_step = (state == S_DLY_ISSUE);
  end

  // Registered datapath: address, latched entry fields and status levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr    <= '0;
      bus_dc      <= 1'b0;
      bus_data    <= '0;
      delay_value <= '0;
      lcd_cs_n    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rom_addr <= seq_base;
            lcd_cs_n <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_DECODE: begin
          unique case (op)
            OP_CMD: begin
              bus_dc   <= 1'b0;
              bus_data <= payload;
            end
            OP_DATA: begin
              bus_dc   <= 1'b1;
              bus_data <= payload;
            end
            OP_DELAY: delay_value <= payload;
            OP_END:   ;
          endcase
        end
        S_BUS_WAIT,
        S_DLY_WAIT: begin
          if (abort) begin
            lcd_cs_n <= 1'b1;
            busy     <= 1'b0;
          end
        end
        // Top of the table acts as an implicit END; the address never wraps.
        S_NEXT: begin
          if (!last_addr) rom_addr <= rom_addr + 1'b1;
        end
        S_FINISH: begin
          lcd_cs_n <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed self-checking bench for lcd_init_sequencer.
// Build with +define+LCD_SEQ_TIMEOUT_EN to exercise the watchdog path.
module tb_lcd_init_sequencer;
  import lcd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  seq_base;
  logic [7:0]  rom_addr;
  logic [17:0] rom_data;
  logic        bus_step, bus_dc, bus_done;
  logic [15:0] bus_data;
  logic        delay_step, delay_done;
  logic [15:0] delay_value;
  logic        lcd_cs_n, busy, done, error;

  logic        resp_bus_done, stray_done;
  logic        bus_resp_en;
  int          bus_lat, dly_lat;
  logic [16:0] wr_q[$];
  logic [15:0] dly_q[$];
  int          cs_bad, addr0_seen;
  logic [17:0] rom [256];

  int errors = 0;
  int checks = 0;

  assign bus_done = resp_bus_done | stray_done;

  always #5 clk = ~clk;

  lcd_init_sequencer #(
    .DATA_W      (16),
    .ADDR_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seq_base    (seq_base),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .bus_step    (bus_step),
    .bus_dc      (bus_dc),
    .bus_data    (bus_data),
    .bus_done    (bus_done),
    .delay_step  (delay_step),
    .delay_value (delay_value),
    .delay_done  (delay_done),
    .lcd_cs_n    (lcd_cs_n),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Bus writer model: logs each request, answers after bus_lat cycles.
  initial begin
    resp_bus_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_step === 1'b1) begin
        wr_q.push_back({bus_dc, bus_data});
        if (bus_resp_en) begin
          repeat (bus_lat) @(negedge clk);
          resp_bus_done = 1'b1;
          @(negedge clk);
          resp_bus_done = 1'b0;
        end
      end
    end
  end

  // Delay timer model.
  initial begin
    delay_done = 1'b0;
    forever begin
      @(negedge clk);
      if (delay_step === 1'b1) begin
        dly_q.push_back(delay_value);
        repeat (dly_lat) @(negedge clk);
        delay_done = 1'b1;
        @(negedge clk);
        delay_done = 1'b0;
      end
    end
  end

  initial begin
    cs_bad     = 0;
    addr0_seen = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && lcd_cs_n !== 1'b0) cs_bad++;
      if (busy === 1'b1 && rom_addr == 8'h00) addr0_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start at a negedge; returns at the negedge after the accept edge.
  task automatic do_start(input logic [7:0] base);
    seq_base = base;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done === 1'b1 && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_bus_step(input string tag, input int budget);
    int n;
    n = 0;
    while (bus_step !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int w0, d0, c0, a0;
    rst = 1'b1; start = 1'b0; seq_base = '0; stray_done = 1'b0;
    bus_resp_en = 1'b1; bus_lat = 1; dly_lat = 3;
    for (int unsigned i = 0; i < 256; i++) rom[i] = pack_entry(OP_END, 16'h0000);
    rom[8'h00] = pack_entry(OP_CMD,   16'h0011);
    rom[8'h01] = pack_entry(OP_DELAY, 16'h0078);
    rom[8'h02] = pack_entry(OP_CMD,   16'h0029);
    rom[8'h03] = pack_entry(OP_DATA,  16'hA5A5);
    rom[8'h04] = pack_entry(OP_END,   16'h0000);
    rom[8'h40] = pack_entry(OP_CMD,   16'h0010);
    rom[8'h41] = pack_entry(OP_END,   16'h0000);
    rom[8'hFE] = pack_entry(OP_DATA,  16'h0001);
    rom[8'hFF] = pack_entry(OP_DATA,  16'h0002);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_status", {28'd0, lcd_cs_n, busy, done, error}, 32'h8);
    chk("reset_strobes", {30'd0, bus_step, delay_step}, 32'h0);
    chk("reset_rom_addr", {24'd0, rom_addr}, 32'h0);
    chk("reset_bus", {15'd0, bus_dc, bus_data}, 32'h0);

    // Sequence at 0x00: CMD 11, DELAY 78, CMD 29, DATA A5A5, END.
    w0 = wr_q.size(); d0 = dly_q.size(); c0 = cs_bad;
    do_start(8'h00);
    chk("start_cs_busy", {30'd0, lcd_cs_n, busy}, 32'h1);
    wait_done("seq0_done_timeout", 200);
    chk("seq0_nwrites", wr_q.size() - w0, 3);
    if (wr_q.size() - w0 == 3) begin
      chk("seq0_w0", 32'(wr_q[w0]),   32'h00011);
      chk("seq0_w1", 32'(wr_q[w0+1]), 32'h00029);
      chk("seq0_w2", 32'(wr_q[w0+2]), 32'h1A5A5);
    end
    chk("seq0_ndelays", dly_q.size() - d0, 1);
    if (dly_q.size() - d0 == 1) chk("seq0_delay_val", 32'(dly_q[d0]), 32'h78);
    chk("seq0_cs_low", cs_bad - c0, 0);
    chk("seq0_end_status", {28'd0, lcd_cs_n, busy, done, error}, 32'hA);
    chk("seq0_end_addr", {24'd0, rom_addr}, 32'h04);

    // Second sequence at 0x40; done drops on accept.
    w0 = wr_q.size();
    do_start(8'h40);
    chk("seq40_done_drop", {31'd0, done}, 32'h0);
    wait_done("seq40_done_timeout", 200);
    chk("seq40_nwrites", wr_q.size() - w0, 1);
    if (wr_q.size() - w0 == 1) chk("seq40_w0", 32'(wr_q[w0]), 32'h00010);
    chk("seq40_done", {31'd0, done}, 32'h1);

    // Top-of-table run: implicit END, no wrap to 0x00.
    w0 = wr_q.size(); a0 = addr0_seen;
    do_start(8'hFE);
    wait_done("seqFE_done_timeout", 200);
    chk("seqFE_nwrites", wr_q.size() - w0, 2);
    if (wr_q.size() - w0 == 2) begin
      chk("seqFE_w0", 32'(wr_q[w0]),   32'h10001);
      chk("seqFE_w1", 32'(wr_q[w0+1]), 32'h10002);
    end
    chk("seqFE_no_wrap", addr0_seen - a0, 0);
    chk("seqFE_end_addr", {24'd0, rom_addr}, 32'hFF);

    // Stray bus_done and start while busy are ignored.
    w0 = wr_q.size(); d0 = dly_q.size();
    do_start(8'h00);
    stray_done = 1'b1;           // FETCH cycle
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    do_start(8'h40);             // busy: must not restart
    wait_done("busy_done_timeout", 200);
    chk("busy_nwrites", wr_q.size() - w0, 3);
    if (wr_q.size() - w0 == 3) begin
      chk("busy_w0", 32'(wr_q[w0]),   32'h00011);
      chk("busy_w2", 32'(wr_q[w0+2]), 32'h1A5A5);
    end
    chk("busy_ndelays", dly_q.size() - d0, 1);
    stray_done = 1'b1;           // idle
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stray", {31'd0, busy}, 32'h0);

    // Reset during BUS_WAIT: outputs return to reset values asynchronously.
    bus_lat = 20;
    do_start(8'h00);
    wait_bus_step("rst_step_timeout", 50);
    @(negedge clk);              // BUS_WAIT
    #2 rst = 1'b1;
    #1;
    chk("rst_async_status", {28'd0, lcd_cs_n, busy, done, error}, 32'h8);
    chk("rst_async_data", {15'd0, bus_dc, bus_data}, 32'h0);
    chk("rst_async_dly", {16'd0, delay_value}, 32'h0);
    chk("rst_async_addr", {24'd0, rom_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    bus_lat = 1;
    w0 = wr_q.size();
    do_start(8'h00);
    wait_done("rerun_done_timeout", 200);
    chk("rerun_nwrites", wr_q.size() - w0, 3);
    if (wr_q.size() - w0 == 3) chk("rerun_w1", 32'(wr_q[w0+1]), 32'h00029);

    // Bus never answers.
    bus_resp_en = 1'b0;
    do_start(8'h00);
    wait_bus_step("to_step_timeout", 50);
`ifdef LCD_SEQ_TIMEOUT_EN
    repeat (16) @(negedge clk);
    chk("to_before_limit", {30'd0, error, busy}, 32'h1);
    @(negedge clk);
    chk("to_at_limit", {28'd0, lcd_cs_n, busy, done, error}, 32'h9);
`else
    repeat (40) @(negedge clk);
    chk("no_to_hang", {28'd0, lcd_cs_n, busy, done, error}, 32'h4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
    bus_resp_en = 1'b1;
    repeat (2) @(negedge clk);
    do_start(8'h40);
    chk("recover_err_clear", {31'd0, error}, 32'h0);
    wait_done("recover_done_timeout", 200);
    chk("recover_status", {28'd0, lcd_cs_n, busy, done, error}, 32'hA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
